addr_gen_param: RTL and testbench

Parametrised address generator for the integer-pel motion-estimation datapath. It walks a two-field search-window address `{w, h}` column by column from a loaded initial motion vector, and separately counts template-block addresses. It adds a start/busy/done handshake and self-terminates after a configurable number of columns. It sits between the ME controller and the search-window / template-block RAMs.

---
 rtl/me_addr_pkg.sv | 39 +++
 rtl/addr_gen_param_mod_counter.sv | 38 +++
 rtl/addr_gen_param.sv | 157 +++++++++++++++
 tb/tb_addr_gen_param.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/me_addr_pkg.sv
// Shared types and helpers for the motion-estimation address generator.
// FSM state enum, default geometry constants and {w, h} field-select helpers.
package me_addr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_CW      = 6;
    localparam int DEF_COL_LEN = 18;
    localparam int DEF_NUM_COL = 18;
    localparam int DEF_TBW     = 8;

    // Helpers operate on a fixed maximum field width; callers cast to CW.
    localparam int MAX_CW = 16;

    function automatic logic [MAX_CW-1:0] sel_h(input logic [2*MAX_CW-1:0] a, input int cw);
        logic [2*MAX_CW-1:0] mask;
        mask = (32'd1 << cw) - 32'd1;
        return MAX_CW'(a & mask);
    endfunction

    function automatic logic [MAX_CW-1:0] sel_w(input logic [2*MAX_CW-1:0] a, input int cw);
        logic [2*MAX_CW-1:0] mask;
        mask = (32'd1 << cw) - 32'd1;
        return MAX_CW'((a >> cw) & mask);
    endfunction

    function automatic logic [2*MAX_CW-1:0] pack_wh(input logic [MAX_CW-1:0] w,
                                                    input logic [MAX_CW-1:0] h,
                                                    input int cw);
        logic [2*MAX_CW-1:0] mask;
        mask = (32'd1 << cw) - 32'd1;
        return (((2*MAX_CW)'(w) & mask) << cw) | ((2*MAX_CW)'(h) & mask);
    endfunction

endpackage

// File: rtl/addr_gen_param_mod_counter.sv
// Enable counter with synchronous clear; wraps to zero after reaching TERM.
// tc is high while the count equals TERM.
module mod_counter #(
    parameter int W    = 4,
    parameter int TERM = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc  = (cnt_q == W'(TERM));
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/addr_gen_param.sv
// Column-major search-window address walker plus free-running template counter.
// Optional sticky wrap flag oob when ADDR_GEN_BOUND_CHK_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start; en_sw ignored
// RUN     | stepping addr_sw on each en_sw
// DONE    | one-cycle done pulse, returns to IDLE
module addr_gen_param
    import me_addr_pkg::*;
#(
    parameter int CW      = DEF_CW,
    parameter int COL_LEN = DEF_COL_LEN,
    parameter int NUM_COL = DEF_NUM_COL,
    parameter int TBW     = DEF_TBW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            start,
    input  logic [2*CW-1:0] init_mvec,
    input  logic            en_sw,
    input  logic            en_tb,
    output logic [2*CW-1:0] addr_sw,
    output logic [TBW-1:0]  addr_tb,
    output logic            busy,
    output logic            done
`ifdef ADDR_GEN_BOUND_CHK_EN
    ,
    output logic            oob
`endif
);

    localparam int AW = 2 * CW;
    localparam int HW = (COL_LEN > 1) ? $clog2(COL_LEN) : 1;
    localparam int WW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_sw_q, addr_sw_d;
    logic [CW-1:0]   h_cur, w_cur, h_inc, h_ret, w_inc;
    logic [HW-1:0]   cnt_h;
    logic [WW-1:0]   cnt_w;
    logic            h_tc, w_tc;
    logic            start_acc, adv_h, adv_col, cnt_clr;

    assign h_cur = CW'(sel_h((2*MAX_CW)'(addr_sw_q), CW));
    assign w_cur = CW'(sel_w((2*MAX_CW)'(addr_sw_q), CW));
    assign h_inc = h_cur + 1'b1;
    assign h_ret = h_cur - CW'(COL_LEN - 1);
    assign w_inc = w_cur + 1'b1;

    always_comb begin
        state_d   = state_q;
        addr_sw_d = addr_sw_q;
        start_acc = 1'b0;
        adv_h     = 1'b0;
        adv_col   = 1'b0;
        if (clr) begin
            state_d   = ST_IDLE;
            addr_sw_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        start_acc = 1'b1;
                        state_d   = ST_RUN;
                        addr_sw_d = init_mvec;
                    end
                end
                ST_RUN: begin
                    if (en_sw) begin
                        if (!h_tc) begin
                            adv_h     = 1'b1;
                            addr_sw_d = AW'(pack_wh(MAX_CW'(w_cur), MAX_CW'(h_inc), CW));
                        end else if (!w_tc) begin
                            adv_col   = 1'b1;
                            addr_sw_d = AW'(pack_wh(MAX_CW'(w_inc), MAX_CW'(h_ret), CW));
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign cnt_clr = clr | start_acc;

    // cnt_h wraps to zero by itself on the column turn since it sits at its terminal.
    mod_counter #(.W(HW), .TERM(COL_LEN - 1)) u_cnt_h (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (adv_h | adv_col),
        .cnt   (cnt_h),
        .tc    (h_tc)
    );

    mod_counter #(.W(WW), .TERM(NUM_COL - 1)) u_cnt_w (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (adv_col),
        .cnt   (cnt_w),
        .tc    (w_tc)
    );

    mod_counter #(.W(TBW), .TERM((2 ** TBW) - 1)) u_cnt_tb (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en_tb),
        .cnt   (addr_tb),
        .tc    ()
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_sw_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_sw_q <= addr_sw_d;
        end
    end

    assign addr_sw = addr_sw_q;
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);

`ifdef ADDR_GEN_BOUND_CHK_EN
    logic oob_q, oob_d;

    always_comb begin
        oob_d = oob_q;
        if (clr || start_acc) begin
            oob_d = 1'b0;
        end else if (adv_h && (h_cur == '1)) begin
            oob_d = 1'b1;
        end else if (adv_col && ((w_cur == '1) || (32'(h_cur) < 32'(COL_LEN - 1)))) begin
            oob_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_q <= 1'b0;
        end else begin
            oob_q <= oob_d;
        end
    end

    assign oob = oob_q;
`endif

endmodule

// File: tb/tb_addr_gen_param.sv
// Scoreboard bench for addr_gen_param: a behavioural scan model pushes expected
// outputs per cycle, a monitor pops and compares after each clock edge.
module tb_addr_gen_param;
    import me_addr_pkg::*;

    localparam int CW      = DEF_CW;
    localparam int COL_LEN = DEF_COL_LEN;
    localparam int NUM_COL = DEF_NUM_COL;
    localparam int TBW     = DEF_TBW;
    localparam int AW      = 2 * CW;
    localparam int M       = 1 << CW;
    localparam int TOTAL   = COL_LEN * NUM_COL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr, start, en_sw, en_tb;
    logic [AW-1:0] init_mvec;
    logic [AW-1:0] addr_sw;
    logic [TBW-1:0] addr_tb;
    logic          busy, done;
`ifdef ADDR_GEN_BOUND_CHK_EN
    logic          oob;
`endif

    addr_gen_param dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .start     (start),
        .init_mvec (init_mvec),
        .en_sw     (en_sw),
        .en_tb     (en_tb),
        .addr_sw   (addr_sw),
        .addr_tb   (addr_tb),
        .busy      (busy),
        .done      (done)
`ifdef ADDR_GEN_BOUND_CHK_EN
        ,
        .oob       (oob)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]  a;
        logic [TBW-1:0] tb;
        logic           busy;
        logic           done;
        logic           oob;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // model state: mode 0 idle, 1 scanning, 2 finished pulse
    int m_mode, m_idx, m_w0, m_h0, m_w, m_h, m_tb;
    bit m_oob;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", name, got, want, $time);
    endtask

    function automatic void model_reset();
        m_mode = 0; m_idx = 0; m_w0 = 0; m_h0 = 0; m_w = 0; m_h = 0; m_tb = 0; m_oob = 0;
    endfunction

    function automatic void model_step(input bit s, input bit e, input bit t, input bit c,
                                       input logic [AW-1:0] mv);
        int nw, nh;
        bit wrap;
        if (c) begin
            model_reset();
            return;
        end
        m_tb = (m_tb + int'(t)) % (1 << TBW);
        case (m_mode)
            0: if (s) begin
                m_mode = 1;
                m_w0 = int'(mv[AW-1:CW]);
                m_h0 = int'(mv[CW-1:0]);
                m_idx = 0; m_w = m_w0; m_h = m_h0; m_oob = 0;
            end
            1: if (e) begin
                if (m_idx == TOTAL - 1) begin
                    m_mode = 2;
                end else begin
                    m_idx++;
                    if (m_idx % COL_LEN != 0) wrap = (m_h + 1 >= M);
                    else wrap = (m_h - (COL_LEN - 1) < 0) || (m_w + 1 >= M);
                    nw = m_w0 + m_idx / COL_LEN;
                    nh = m_h0 + m_idx % COL_LEN;
                    m_w = nw % M;
                    m_h = nh % M;
                    if (wrap) m_oob = 1;
                end
            end
            default: m_mode = 0;
        endcase
    endfunction

    task automatic cyc(input bit s, input bit e, input bit t, input bit c, input logic [AW-1:0] mv);
        exp_t x;
        @(negedge clk);
        start = s; en_sw = e; en_tb = t; clr = c; init_mvec = mv;
        model_step(s, e, t, c, mv);
        x.a    = AW'((m_w << CW) | m_h);
        x.tb   = TBW'(m_tb);
        x.busy = (m_mode == 1);
        x.done = (m_mode == 2);
        x.oob  = m_oob;
        exp_q.push_back(x);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #3;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("sb_addr_sw", 32'(addr_sw), 32'(x.a));
                chk("sb_addr_tb", 32'(addr_tb), 32'(x.tb));
                chk("sb_busy", 32'(busy), 32'(x.busy));
                chk("sb_done", 32'(done), 32'(x.done));
`ifdef ADDR_GEN_BOUND_CHK_EN
                chk("sb_oob", 32'(oob), 32'(x.oob));
`endif
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0; clr = 0; start = 0; en_sw = 0; en_tb = 0; init_mvec = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_addr_sw", 32'(addr_sw), 32'h0);
        chk("reset_addr_tb", 32'(addr_tb), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        rst_n = 1'b1;

        repeat (3) cyc(0, 1, 1, 0, '0);
        chk("idle_en_sw_ignored", 32'(addr_sw), 32'h0);

        // column turn and full scan from w=2, h=3
        cyc(1, 0, 0, 0, 12'h083);
        repeat (17) cyc(0, 1, 0, 0, '0);
        after_edge();
        chk("col_last_h", 32'(addr_sw), 32'h094);
        cyc(0, 1, 0, 0, '0);
        after_edge();
        chk("col_turn", 32'(addr_sw), 32'h0C3);
        repeat (5) cyc(0, 0, 0, 0, '0);
        after_edge();
        chk("stall_frozen", 32'(addr_sw), 32'h0C3);
        cyc(1, 0, 0, 0, 12'hFFF);
        after_edge();
        chk("start_in_run_ignored", 32'(addr_sw), 32'h0C3);
        repeat (305) cyc(0, 1, 0, 0, '0);
        after_edge();
        chk("scan_last_addr", 32'(addr_sw), 32'h4D4);
        chk("scan_busy", 32'(busy), 32'h1);
        cyc(0, 1, 0, 0, '0);
        after_edge();
        chk("term_busy", 32'(busy), 32'h0);
        chk("term_done", 32'(done), 32'h1);
        chk("term_hold", 32'(addr_sw), 32'h4D4);
        cyc(1, 0, 0, 0, 12'h555);
        after_edge();
        chk("done_pulse_end", 32'(done), 32'h0);
        chk("start_in_done_ignored", 32'(busy), 32'h0);

        // wrap from {63, 60}
        cyc(1, 0, 0, 0, 12'hFFC);
        repeat (4) cyc(0, 1, 0, 0, '0);
        after_edge();
        chk("wrap_addr", 32'(addr_sw), 32'hFC0);
`ifdef ADDR_GEN_BOUND_CHK_EN
        chk("wrap_oob", 32'(oob), 32'h1);
`endif
        repeat (3) cyc(0, 0, 1, 0, '0);
        cyc(1, 0, 1, 1, 12'h123);
        after_edge();
        chk("clr_start_addr", 32'(addr_sw), 32'h0);
        chk("clr_start_tb", 32'(addr_tb), 32'h0);
        chk("clr_start_busy", 32'(busy), 32'h0);

        repeat (3000) begin
            cyc(($urandom % 8) == 0, ($urandom % 10) < 7, $urandom % 2,
                ($urandom % 250) == 0, AW'($urandom));
        end

        // asynchronous reset mid-scan
        cyc(1, 0, 1, 0, 12'h7A5);
        repeat (6) cyc(0, 1, 1, 0, '0);
        @(negedge clk);
        start = 0; en_sw = 0; en_tb = 0; clr = 0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_addr_sw", 32'(addr_sw), 32'h0);
        chk("async_rst_addr_tb", 32'(addr_tb), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // template counter wraps after 256 pulses, running while idle
        repeat (255) cyc(0, 0, 1, 0, '0);
        after_edge();
        chk("tb_255", 32'(addr_tb), 32'hFF);
        cyc(0, 0, 1, 0, '0);
        after_edge();
        chk("tb_wrap", 32'(addr_tb), 32'h00);

        cyc(0, 0, 0, 0, '0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
